// File: rtl/ifu_axi_fetch.sv
// Instruction fetch unit: single-outstanding AXI4-Lite read master that fetches
// one instruction per transaction from the current PC and hands {pc, inst, err} downstream.
module ifu_axi_fetch #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic                  arvalid,
    output logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arready,
    input  logic                  rvalid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    output logic                  rready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  out_err,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_OUT
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;      // fetch target; may move ahead of addr on redirect
    logic [ADDR_WIDTH-1:0] addr;    // address of the read in flight / beat held
    logic                  drop;
    logic [DATA_WIDTH-1:0] inst;
    logic                  err;
    logic [ADDR_WIDTH-1:0] pc_inc;

    assign pc_inc    = pc + ADDR_WIDTH'(4);

    assign arvalid   = (state == S_AR);
    assign rready    = (state == S_R);
    assign out_valid = (state == S_OUT);
    assign araddr    = addr;
    assign out_pc    = out_valid ? addr : '0;
    assign out_inst  = out_valid ? inst : '0;
    assign out_err   = out_valid & err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            addr  <= RESET_PC;
            drop  <= 1'b0;
            inst  <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_AR;
                    if (redirect_valid) begin
                        pc   <= redirect_pc;
                        addr <= redirect_pc;
                    end else begin
                        addr <= pc;
                    end
                end
                S_AR: begin
                    // addr stays put until the handshake; the redirect only retargets pc
                    if (redirect_valid) begin
                        pc   <= redirect_pc;
                        drop <= 1'b1;
                    end
                    if (arready) state <= S_R;
                end
                S_R: begin
                    if (redirect_valid) pc <= redirect_pc;
                    if (rvalid && rready) begin
                        drop <= 1'b0;
                        if (drop || redirect_valid) begin
                            state <= S_AR;
                            addr  <= redirect_valid ? redirect_pc : pc;
                        end else begin
                            inst  <= rdata;
                            err   <= |rresp;
                            state <= S_OUT;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                S_OUT: begin
                    // a redirect wins over pc+4 whether or not the beat was taken
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        addr  <= redirect_pc;
                        state <= S_AR;
                    end else if (out_ready) begin
                        pc    <= pc_inc;
                        addr  <= pc_inc;
                        state <= S_AR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Bench for ifu_axi_fetch: directed scenarios with literal expectations, then
// random AXI/downstream/redirect traffic checked every cycle against a fetch-level model.
module tb_ifu_axi_fetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        arvalid, rready, out_valid, out_err;
    logic [31:0] araddr, out_pc, out_inst;
    logic        arready, rvalid, redirect_valid, out_ready;
    logic [31:0] rdata, redirect_pc;
    logic [1:0]  rresp;

    logic        w_arvalid, w_rready, w_out_valid, w_out_err;
    logic [31:0] w_araddr, w_out_pc, w_out_inst;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ifu_axi_fetch u_dut (
        .clk(clk), .rstn(rstn),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_err(out_err), .out_ready(out_ready)
    );

    ifu_axi_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rstn(rstn),
        .arvalid(w_arvalid), .araddr(w_araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(w_rready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(w_out_valid), .out_pc(w_out_pc), .out_inst(w_out_inst),
        .out_err(w_out_err), .out_ready(out_ready)
    );

    // Fetch-level model: at most one fetch alive, described as request / read / held beat.
    logic        m_idle, m_has_ar, m_has_rd, m_has_beat, m_stale;
    logic [31:0] m_pc, m_ar_addr, b_pc, b_inst;
    logic        b_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_has_ar = 1'b0; m_has_rd = 1'b0; m_has_beat = 1'b0; m_stale = 1'b0;
        m_pc = 32'h8000_0000; m_ar_addr = 32'h0; b_pc = 32'h0; b_inst = 32'h0; b_err = 1'b0;
    endtask

    task automatic start_fetch();
        m_has_ar = 1'b1; m_ar_addr = m_pc; m_stale = 1'b0;
    endtask

    task automatic model_step();
        if (m_idle) begin
            m_idle = 1'b0;
            if (redirect_valid) m_pc = redirect_pc;
            start_fetch();
        end else if (m_has_ar) begin
            if (redirect_valid) begin m_pc = redirect_pc; m_stale = 1'b1; end
            if (arready) begin m_has_ar = 1'b0; m_has_rd = 1'b1; end
        end else if (m_has_rd) begin
            if (redirect_valid) begin m_pc = redirect_pc; m_stale = 1'b1; end
            if (rvalid) begin
                m_has_rd = 1'b0;
                if (m_stale) start_fetch();
                else begin
                    m_has_beat = 1'b1; b_pc = m_ar_addr; b_inst = rdata; b_err = (rresp != 2'b00);
                end
            end
        end else if (m_has_beat) begin
            if (redirect_valid) begin
                m_has_beat = 1'b0; m_pc = redirect_pc; start_fetch();
            end else if (out_ready) begin
                m_has_beat = 1'b0; m_pc = b_pc + 32'd4; start_fetch();
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rstn) model_step();
        #1;
    endtask

    task automatic drive(input logic ar, input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                         input logic rdr, input logic [31:0] rpc, input logic ordy);
        arready = ar; rvalid = rv; rdata = rd; rresp = rr;
        redirect_valid = rdr; redirect_pc = rpc; out_ready = ordy;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("arvalid", arvalid, m_has_ar);
        if (m_has_ar) check("araddr", araddr, m_ar_addr);
        check("rready", rready, m_has_rd);
        check("out_valid", out_valid, m_has_beat);
        check("out_pc", out_pc, m_has_beat ? b_pc : 32'h0);
        check("out_inst", out_inst, m_has_beat ? b_inst : 32'h0);
        check("out_err", out_err, m_has_beat & b_err);
    end

    initial begin
        int waited;
        rstn = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        repeat (3) cyc();
        check("reset_arvalid", arvalid, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);

        // basic fetch at RESET_PC
        rstn = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0413, 2'b00, 1'b0, 32'h0, 1'b0);
        cyc();
        check("t1_arvalid", arvalid, 1'b1);
        check("t1_araddr", araddr, 32'h8000_0000);
        check("t1_wrap_araddr", w_araddr, 32'hFFFF_FFFC);
        cyc();
        check("t1_rready", rready, 1'b1);
        cyc();
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_out_pc", out_pc, 32'h8000_0000);
        check("t1_out_inst", out_inst, 32'h0000_0413);
        check("t1_out_err", out_err, 1'b0);
        check("t1_wrap_out_pc", w_out_pc, 32'hFFFF_FFFC);

        // downstream stall holds the beat
        rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t2_hold_valid", out_valid, 1'b1);
            check("t2_hold_inst", out_inst, 32'h0000_0413);
            check("t2_hold_arvalid", arvalid, 1'b0);
        end
        out_ready = 1'b1;
        cyc();
        check("t2_after_out_valid", out_valid, 1'b0);
        check("t2_next_araddr", araddr, 32'h8000_0004);
        check("t2_wrap_next_araddr", w_araddr, 32'h0000_0000);

        // redirect during a stalled AR: address held, beat dropped
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 32'h8000_0100, 1'b1);
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t3_araddr_held", araddr, 32'h8000_0004);
            cyc();
        end
        check("t3_araddr_held", araddr, 32'h8000_0004);
        arready = 1'b1;
        cyc();
        drive(1'b0, 1'b1, 32'h1111_1111, 2'b10, 1'b0, 32'h0, 1'b1);
        cyc();
        check("t3_dropped", out_valid, 1'b0);
        check("t3_new_araddr", araddr, 32'h8000_0100);

        // redirect while holding a beat, without and with handshake
        drive(1'b1, 1'b1, 32'h2222_2222, 2'b00, 1'b0, 32'h0, 1'b0);
        cyc(); cyc();
        check("t4_out_pc", out_pc, 32'h8000_0100);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        cyc();
        redirect_valid = 1'b0;
        check("t4_discard_valid", out_valid, 1'b0);
        check("t4_araddr", araddr, 32'h8000_0200);
        rdata = 32'h3333_3333;
        cyc(); cyc();
        check("t4b_out_pc", out_pc, 32'h8000_0200);
        redirect_valid = 1'b1; out_ready = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        check("t4b_araddr", araddr, 32'h8000_0200);

        // bus error delivered as a normal beat
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b0);
        cyc(); cyc();
        check("t5_out_err", out_err, 1'b1);
        check("t5_out_inst", out_inst, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        cyc();
        check("t5_next_araddr", araddr, 32'h8000_0204);

        // random traffic, with occasional asynchronous resets
        for (int i = 0; i < 4000; i++) begin
            if (rstn && $urandom_range(0, 599) == 0) begin
                rstn = 1'b0;
                model_reset();
            end else begin
                rstn = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 4) != 0);
            cyc();
        end
        rstn = 1'b1;

        // reset while a read is outstanding
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1);
        waited = 0;
        while (!rready && waited < 50) begin
            cyc();
            waited++;
        end
        check("t6_reached_R", rready, 1'b1);
        rstn = 1'b0;
        model_reset();
        #1;
        check("t6_rst_arvalid", arvalid, 1'b0);
        check("t6_rst_rready", rready, 1'b0);
        check("t6_rst_out_valid", out_valid, 1'b0);
        cyc(); cyc();
        rstn = 1'b1;
        cyc();
        check("t6_refetch_araddr", araddr, 32'h8000_0000);
        check("t6_wrap_refetch", w_araddr, 32'hFFFF_FFFC);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifu_axi_fetch.md
Name: ifu_axi_fetch

Overview:
Instruction fetch unit: AXI4-Lite read master that fetches one 32-bit instruction per transaction from the current PC. It sits directly upstream of the pipeline register slice and delivers {pc, inst, err} on a valid/ready handshake. It accepts a redirect from downstream (branch/exception), dropping any in-flight or held fetch. It has no prefetch: at most one outstanding AXI read at a time.

Parameters:
ADDR_WIDTH, 32, width of PC and araddr
DATA_WIDTH, 32, width of rdata and out_inst
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
arvalid  output  1  AXI read-address valid
araddr  output  ADDR_WIDTH  AXI read address (= PC)
arready  input  1  AXI read-address ready
rvalid  input  1  AXI read-data valid
rdata  input  DATA_WIDTH  AXI read data
rresp  input  2  AXI read response
rready  output  1  AXI read-data ready
redirect_valid  input  1  single-cycle redirect request
redirect_pc  input  ADDR_WIDTH  redirect target
out_valid  output  1  fetched beat valid
out_pc  output  ADDR_WIDTH  PC of fetched instruction
out_inst  output  DATA_WIDTH  instruction word
out_err  output  1  1 = bus error on this fetch
out_ready  input  1  downstream ready

Behaviour:
- Clock clk; reset rstn, asynchronous, active-low. All state registers use async reset.
- Reset values: state=IDLE, pc=RESET_PC, drop=0, arvalid=0, rready=0, out_valid=0, out_err=0, out_inst=0. out_pc=0 while out_valid=0.
- arvalid, rready and out_valid are decoded from state. They are never combinationally dependent on inputs.
- States:
  - IDLE: first cycle after reset release. Goes to AR unconditionally. A redirect in IDLE loads pc<=redirect_pc.
  - AR: arvalid=1, araddr=pc. araddr is held stable until arvalid&arready. On that handshake, go to R.
  - R: rready=1. On rvalid&rready:
    - If drop=0: latch inst<=rdata and err<=(rresp!=2'b00); go to OUT.
    - If drop=1: discard the beat; clear drop; go to AR.
  - OUT: out_valid=1. out_pc, out_inst and out_err are stable while out_ready=0. On out_valid&out_ready: pc<=pc+4; go to AR.
- Minimum latency: AR handshake at cycle n, R handshake at cycle n+1, out_valid at n+2. Next arvalid is asserted the cycle after the out handshake.
- Redirect handling (redirect_valid sampled every cycle; pc is the target register):
  - AR: the AXI address must not change mid-request, so araddr keeps the old pc. pc<=redirect_pc and drop<=1 take effect at the next edge. If the AR handshake happens in the same cycle, the transfer uses the old address and drop is still set.
  - R: pc<=redirect_pc and drop<=1. If rvalid&rready occur in the same cycle, that beat is dropped, drop stays 0, and the FSM goes to AR with the new pc.
  - OUT, no out handshake: the held beat is discarded. out_valid=0 next cycle; pc<=redirect_pc; go to AR.
  - OUT with out_valid&out_ready in the same cycle: the beat counts as delivered, and the next fetch uses redirect_pc (not pc+4).
  - Multiple redirects before resolution: the last one wins. drop is a single bit because at most one read is outstanding.
  - A dropped beat never reaches the output, even if rresp is an error.
- Arithmetic: pc+4 is modulo 2^ADDR_WIDTH. Low pc bits are passed through unchecked. Misalignment is downstream's concern.
- out_inst is forced to 0 when out_valid=0. out_err is 0 when out_valid=0.
- Bus error: out_err=1 and out_inst=rdata are delivered as a normal beat. Fetching continues at pc+4 unless redirected.
- Reset mid-transaction: all state clears immediately, and no AXI handshake is completed on the reset edge. The interconnect is reset by the same rstn.
- rvalid while not in R is ignored (rready=0). arready while not in AR is ignored.

Test Plan:
1. Release reset; arready=1; rvalid=1 one cycle after AR with rdata=32'h0000_0413 -> araddr=0x8000_0000; out_valid at AR+2 with out_pc=0x8000_0000, out_inst=0x0000_0413, out_err=0. Next araddr=0x8000_0004.
2. Hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1 and outputs are stable; arvalid=0 throughout. Release out_ready -> one transfer, then AR at 0x8000_0004.
3. arready delayed 3 cycles; redirect_pc=0x8000_0100 pulsed in cycle 1 of AR -> araddr stays at old pc until handshake; returned beat is dropped (no out_valid); next araddr=0x8000_0100.
4. Redirect 0x8000_0200 in OUT with out_ready=0 -> out_valid=0 next cycle; next araddr=0x8000_0200. Repeat with out_ready=1 in the same cycle -> beat transfers, and the next araddr is still 0x8000_0200.
5. rresp=2'b10 with rdata=0xDEAD_BEEF -> out_err=1, out_inst=0xDEAD_BEEF; next fetch at pc+4.
6. RESET_PC=32'hFFFF_FFFC, complete one fetch -> next araddr=0x0000_0000. Assert rstn=0 while in R -> arvalid, rready and out_valid are 0 immediately; after release, refetch from RESET_PC.
